// File: rtl/burst_server.sv
// Shared-resource burst executor: runs a `size`-beat burst per accepted start,
// pulses done, then holds off for GAP turnaround cycles. Keeps debug counters.
module burst_server #(
  parameter int SIZE_W = 3,
  parameter int CNT_W  = 8,
  parameter int GAP    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [SIZE_W-1:0] size,
  input  logic              owner,
  output logic              busy,
  output logic              beat,
  output logic [SIZE_W-1:0] beat_idx,
  output logic              beat_owner,
  output logic              done,
  output logic [CNT_W-1:0]  cnt_a,
  output logic [CNT_W-1:0]  cnt_b,
  output logic              proto_err
);

  typedef enum logic [1:0] {IDLE, RUN, FIN, TURN} state_t;

  localparam logic [2:0] GAP_LAST = (GAP > 0) ? 3'(GAP - 1) : 3'd0;

  state_t            state, nxt;
  logic [SIZE_W-1:0] size_q;
  logic [SIZE_W-1:0] idx_nxt;
  logic [2:0]        gap_cnt, gap_nxt;
  logic              accept;

  assign accept = (state == IDLE) && start;

  always_comb begin
    nxt     = state;
    idx_nxt = '0;
    gap_nxt = '0;
    case (state)
      IDLE: begin
        if (start) nxt = (size == '0) ? FIN : RUN;
      end
      RUN: begin
        if (beat_idx == size_q - SIZE_W'(1)) nxt = FIN;
        else idx_nxt = beat_idx + SIZE_W'(1);
      end
      FIN: begin
        nxt = (GAP > 0) ? TURN : IDLE;
      end
      TURN: begin
        if (gap_cnt == GAP_LAST) nxt = IDLE;
        else gap_nxt = gap_cnt + 3'd1;
      end
      default: nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      size_q     <= '0;
      gap_cnt    <= '0;
      busy       <= 1'b0;
      beat       <= 1'b0;
      beat_idx   <= '0;
      beat_owner <= 1'b0;
      done       <= 1'b0;
      cnt_a      <= '0;
      cnt_b      <= '0;
      proto_err  <= 1'b0;
    end else begin
      state    <= nxt;
      gap_cnt  <= gap_nxt;
      beat_idx <= idx_nxt;
      busy     <= (nxt != IDLE);
      beat     <= (nxt == RUN);
      done     <= (nxt == FIN);
      if (accept) begin
        size_q     <= size;
        beat_owner <= owner;
      end
      if ((start && state != IDLE) || (accept && size == '0)) proto_err <= 1'b1;
      if (state == FIN) begin
        if (!beat_owner) begin
          if (cnt_a != '1) cnt_a <= cnt_a + CNT_W'(1);
        end else begin
          if (cnt_b != '1) cnt_b <= cnt_b + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_burst_server.sv
// Randomized bench for burst_server: two instances (GAP=1/CNT_W=8 and
// GAP=0/CNT_W=2) share stimulus and are compared against a timeline model.
module tb_burst_server;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] size;
  logic       owner;

  logic       busy0, beat0, owner0, done0, err0;
  logic [2:0] idx0;
  logic [7:0] ca0, cb0;
  logic       busy1, beat1, owner1, done1, err1;
  logic [2:0] idx1;
  logic [1:0] ca1, cb1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  burst_server #(.SIZE_W(3), .CNT_W(8), .GAP(1)) u0 (
    .clk(clk), .reset(reset), .start(start), .size(size), .owner(owner),
    .busy(busy0), .beat(beat0), .beat_idx(idx0), .beat_owner(owner0),
    .done(done0), .cnt_a(ca0), .cnt_b(cb0), .proto_err(err0)
  );

  burst_server #(.SIZE_W(3), .CNT_W(2), .GAP(0)) u1 (
    .clk(clk), .reset(reset), .start(start), .size(size), .owner(owner),
    .busy(busy1), .beat(beat1), .beat_idx(idx1), .beat_owner(owner1),
    .done(done1), .cnt_a(ca1), .cnt_b(cb1), .proto_err(err1)
  );

  // Model: each accepted burst is described by its start edge t0, size and owner;
  // all outputs are derived from the distance k = t - t0.
  int t;
  bit act[2];
  int t0[2], sz[2], ow[2], ca[2], cb[2], er[2];
  int gap[2]  = '{1, 0};
  int cmax[2] = '{255, 3};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0d)", tag, got, exp, t);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      act[i] = 1'b0; t0[i] = 0; sz[i] = 0; ow[i] = 0;
      ca[i] = 0; cb[i] = 0; er[i] = 0;
    end
  endtask

  task automatic model_edge();
    t++;
    if (!reset) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      int e;
      bit idle;
      e = act[i] ? sz[i] : 0;
      if (act[i] && (t - t0[i]) == e + 1) begin
        if (ow[i] == 0) ca[i] = (ca[i] < cmax[i]) ? ca[i] + 1 : ca[i];
        else            cb[i] = (cb[i] < cmax[i]) ? cb[i] + 1 : cb[i];
      end
      idle = !act[i] || (t - t0[i]) >= e + 2 + gap[i];
      if (start) begin
        if (idle) begin
          act[i] = 1'b1; t0[i] = t; sz[i] = int'(size); ow[i] = int'(owner);
          if (size == 3'd0) er[i] = 1;
        end else begin
          er[i] = 1;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      int k;
      bit eb;
      k  = t - t0[i];
      eb = act[i] && sz[i] != 0 && k < sz[i];
      check($sformatf("busy%0d", i),  i == 0 ? 32'(busy0)  : 32'(busy1),  32'(act[i] && k <= sz[i] + gap[i]));
      check($sformatf("beat%0d", i),  i == 0 ? 32'(beat0)  : 32'(beat1),  32'(eb));
      check($sformatf("idx%0d", i),   i == 0 ? 32'(idx0)   : 32'(idx1),   eb ? 32'(k) : 32'd0);
      check($sformatf("owner%0d", i), i == 0 ? 32'(owner0) : 32'(owner1), 32'(ow[i]));
      check($sformatf("done%0d", i),  i == 0 ? 32'(done0)  : 32'(done1),  32'(act[i] && k == sz[i]));
      check($sformatf("cnt_a%0d", i), i == 0 ? 32'(ca0)    : 32'(ca1),    32'(ca[i]));
      check($sformatf("cnt_b%0d", i), i == 0 ? 32'(cb0)    : 32'(cb1),    32'(cb[i]));
      check($sformatf("err%0d", i),   i == 0 ? 32'(err0)   : 32'(err1),   32'(er[i]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic pulse(input logic [2:0] s, input logic o, input int wait_n);
    start = 1'b1; size = s; owner = o;
    step();
    start = 1'b0;
    repeat (wait_n) step();
  endtask

  task automatic async_reset();
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    step();
    reset = 1'b1;
  endtask

  initial begin
    t = 0;
    model_reset();
    reset = 1'b0; start = 1'b0; size = '0; owner = 1'b0;
    #1;
    check_all();
    step();
    step();
    reset = 1'b1;
    step();

    pulse(3'd1, 1'b0, 5);
    // size 4 for A, then B exactly at the first accepting edge of the GAP=1 instance
    pulse(3'd4, 1'b0, 6);
    pulse(3'd2, 1'b1, 6);
    // start during RUN is ignored but flagged
    pulse(3'd4, 1'b0, 2);
    pulse(3'd1, 1'b1, 7);
    pulse(3'd0, 1'b1, 4);
    // reset with beat_idx == 2 visible
    pulse(3'd4, 1'b1, 2);
    check("mid_idx", 32'(idx0), 32'd2);
    async_reset();
    pulse(3'd3, 1'b1, 6);

    // start held high: back-to-back bursts, saturates the 2-bit counter
    async_reset();
    start = 1'b1; size = 3'd1; owner = 1'b0;
    repeat (20) step();
    start = 1'b0;
    repeat (4) step();
    check("sat_a1", 32'(ca1), 32'd3);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 249) == 0) begin
        async_reset();
      end else begin
        start = ($urandom_range(0, 3) == 0);
        size  = 3'($urandom);
        owner = 1'($urandom);
        step();
      end
    end
    start = 1'b0;
    repeat (12) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
